sdm_decimator: RTL and testbench

Receive-side counterpart of the first-order sigma-delta modulator. It converts the 1-bit modulator bitstream back into signed PCM samples. The datapath is an N-stage CIC (Hogenauer) decimation filter followed by a power-of-two rescale and saturation to the DAC word width. It sits in loopback and measurement paths, fed directly by the modulator's `dout`, and produces one PCM word per R accepted bits with a single-cycle valid strobe.

---
 rtl/sdm_decimator_if.sv | 16 +
 rtl/sdm_decimator.sv | 136 +++++++++++++
 tb/tb_sdm_decimator.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sdm_decimator_if.sv
// rtl/sdm_decimator_if.sv - bitstream-in / PCM-out bundle for the sigma-delta decimator
//   din, din_valid   : modulator bit and its qualifier (source -> decimator)
//   dout, dout_valid : signed PCM word and its one-clk strobe (decimator -> sink)
//   locked           : decimator has finished warm-up
interface sdm_decimator_if #(
    parameter int dout_bw = 16
);
    logic                      din;
    logic                      din_valid;
    logic signed [dout_bw-1:0] dout;
    logic                      dout_valid;
    logic                      locked;

    modport master (output din, din_valid, input dout, dout_valid, locked);
    modport slave  (input din, din_valid, output dout, dout_valid, locked);
endinterface

// File: rtl/sdm_decimator.sv
// rtl/sdm_decimator.sv - CIC decimator turning a 1-bit sigma-delta stream into signed PCM
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sdm_decimator_if (din/din_valid in, dout/dout_valid/locked out)
module sdm_decimator #(
    parameter int order   = 3,
    parameter int log2_r  = 6,
    parameter int dout_bw = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    sdm_decimator_if.slave  bus
);
    localparam int w     = order * log2_r + 2;
    localparam int shift = order * log2_r - dout_bw + 1;
    localparam int wc    = $clog2(order + 1);

    localparam logic signed [w-1:0] p_max = {{(w-dout_bw+1){1'b0}}, {(dout_bw-1){1'b1}}};
    localparam logic signed [w-1:0] p_min = ~p_max;

    typedef enum logic {WARMUP, RUN} state_t;

    logic signed [w-1:0]       integ_q [order];
    logic signed [w-1:0]       integ_d [order];
    logic signed [w-1:0]       dly_q   [order];
    logic signed [w-1:0]       dly_d   [order];
    logic signed [w-1:0]       dec_q;
    logic signed [w-1:0]       s;
    logic signed [w-1:0]       acc_i;
    logic signed [w-1:0]       acc_c;
    logic signed [w-1:0]       y;
    logic signed [w-1:0]       sat;
    logic [log2_r-1:0]         cnt_q;
    logic [wc-1:0]             wcnt_q;
    logic                      dec_load_q;
    logic                      comb_go_q;
    logic                      emit;
    logic                      dout_valid_q;
    logic signed [dout_bw-1:0] dout_q;
    state_t                    state_q;
    state_t                    state_d;

    // Integrator cascade and comb cascade are both evaluated as a ripple chain
    // inside one cycle, so the last integrator already includes the current bit
    // and the last comb output is ready for rescaling in the update cycle.
    always_comb begin
        s     = bus.din ? {w{1'b1}} : {{(w-1){1'b0}}, 1'b1};
        acc_i = s;
        for (int k = 0; k < order; k++) begin
            acc_i      = integ_q[k] + acc_i;
            integ_d[k] = acc_i;
        end
        acc_c = dec_q;
        for (int k = 0; k < order; k++) begin
            dly_d[k] = acc_c;
            acc_c    = acc_c - dly_q[k];
        end
        y = acc_c >>> shift;
        if (y > p_max) begin
            sat = p_max;
        end else if (y < p_min) begin
            sat = p_min;
        end else begin
            sat = y;
        end
    end

    // Warm-up: wcnt_q counts discarded samples; the sample arriving once it
    // has reached `order` is the first one published and flips us to RUN.
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        if (comb_go_q) begin
            if (state_q == RUN) begin
                emit = 1'b1;
            end else if (wcnt_q == wc'(order)) begin
                emit    = 1'b1;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WARMUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < order; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            dec_q        <= '0;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            dec_load_q   <= 1'b0;
            comb_go_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            dec_load_q <= 1'b0;
            if (bus.din_valid) begin
                for (int k = 0; k < order; k++) begin
                    integ_q[k] <= integ_d[k];
                end
                cnt_q      <= cnt_q + log2_r'(1);
                dec_load_q <= (cnt_q == '1);
            end
            // The decimated sample moves down the pipe regardless of din_valid.
            comb_go_q <= dec_load_q;
            if (dec_load_q) begin
                dec_q <= integ_q[order-1];
            end
            if (comb_go_q) begin
                for (int k = 0; k < order; k++) begin
                    dly_q[k] <= dly_d[k];
                end
                if (state_q == WARMUP && wcnt_q != wc'(order)) begin
                    wcnt_q <= wcnt_q + wc'(1);
                end
            end
            dout_valid_q <= emit;
            if (emit) begin
                dout_q <= dout_bw'(sat);
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.locked     = (state_q == RUN);
endmodule

// File: tb/tb_sdm_decimator.sv
// tb/tb_sdm_decimator.sv - self-checking bench for sdm_decimator against an FIR-equivalent model
module tb_sdm_decimator;
    localparam int ORDER   = 3;
    localparam int LOG2_R  = 6;
    localparam int DOUT_BW = 16;
    localparam int R       = 1 << LOG2_R;
    localparam int HL      = ORDER * (R - 1) + 1;
    localparam int SHIFT   = ORDER * LOG2_R - DOUT_BW + 1;
    localparam int YMAX    = (1 << (DOUT_BW - 1)) - 1;
    localparam int YMIN    = -(1 << (DOUT_BW - 1));

    typedef struct {
        int due;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    sdm_decimator_if #(.dout_bw(DOUT_BW)) bus();

    sdm_decimator #(.order(ORDER), .log2_r(LOG2_R), .dout_bw(DOUT_BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t expq[$];
    int   hist[$];
    int   h[HL];
    int   tmp[HL];
    int   cyc;
    int   nacc;
    int   checks;
    int   errors;
    int   held;
    int   u;
    int   diff;
    logic locked_exp;
    logic lb;
    logic signed [DOUT_BW-1:0] exp_dout;

    // CIC of order N, ratio R is the FIR (1 + z^-1 + ... + z^-(R-1))^N
    // sampled every R inputs, from an all-zero start.
    function automatic int model_sample();
        longint v = 0;
        int     n = hist.size() - 1;
        for (int j = 0; j < HL; j++) begin
            if (n - j >= 0) v += longint'(h[j]) * longint'(hist[n-j]);
        end
        v = v >>> SHIFT;
        if (v > YMAX) v = YMAX;
        if (v < YMIN) v = YMIN;
        return int'(v);
    endfunction

    // First-order modulator: level +32768 for bit 0, -32768 for bit 1.
    function automatic logic mod_bit(input int x);
        logic b;
        b = (u >= 0) ? 1'b0 : 1'b1;
        u = u + x - (b ? -32768 : 32768);
        return b;
    endfunction

    task automatic step(input logic b, input logic v);
        bus.din       = b;
        bus.din_valid = v;
        @(posedge clk);
        cyc++;
        if (rst_n && v) begin
            hist.push_back(b ? -1 : 1);
            while (hist.size() > HL) void'(hist.pop_front());
            nacc++;
            if (nacc % R == 0 && nacc / R > ORDER) expq.push_back('{cyc + 2, model_sample()});
        end
        #1;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            checks++;
            assert (bus.dout_valid === 1'b1) else begin
                errors++;
                $error("FAIL strobe_missing cyc=%0d dout_valid=%b expected=1", cyc, bus.dout_valid);
            end
            held       = expq[0].val;
            locked_exp = 1'b1;
            void'(expq.pop_front());
        end else begin
            checks++;
            assert (bus.dout_valid === 1'b0) else begin
                errors++;
                $error("FAIL strobe_extra cyc=%0d dout_valid=%b expected=0", cyc, bus.dout_valid);
            end
        end
        exp_dout = DOUT_BW'(held);
        checks++;
        assert (bus.dout === exp_dout) else begin
            errors++;
            $error("FAIL dout cyc=%0d dout=%0d expected=%0d", cyc, bus.dout, exp_dout);
        end
        checks++;
        assert (bus.locked === locked_exp) else begin
            errors++;
            $error("FAIL locked cyc=%0d locked=%b expected=%b", cyc, bus.locked, locked_exp);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (bus.dout === '0) else begin
            errors++;
            $error("FAIL rst_dout dout=%0d expected=0", bus.dout);
        end
        checks++;
        assert (bus.dout_valid === 1'b0) else begin
            errors++;
            $error("FAIL rst_valid dout_valid=%b expected=0", bus.dout_valid);
        end
        checks++;
        assert (bus.locked === 1'b0) else begin
            errors++;
            $error("FAIL rst_locked locked=%b expected=0", bus.locked);
        end
        expq.delete();
        hist.delete();
        nacc       = 0;
        held       = 0;
        locked_exp = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        cyc = 0; nacc = 0; checks = 0; errors = 0; held = 0; u = 0;
        locked_exp = 1'b0;

        for (int i = 0; i < HL; i++) h[i] = 0;
        h[0] = 1;
        for (int s = 0; s < ORDER; s++) begin
            for (int i = 0; i < HL; i++) begin
                tmp[i] = 0;
                for (int j = 0; j < R; j++) if (i >= j) tmp[i] += h[i-j];
            end
            for (int i = 0; i < HL; i++) h[i] = tmp[i];
        end

        do_reset();

        // Positive full scale: first strobe 2 clks after bit 256, then every R.
        repeat (R * (ORDER + 1) + 6 * R) step(1'b0, 1'b1);

        // Reset right after a block boundary: the in-flight sample is dropped.
        do_reset();

        // Negative full scale.
        repeat (R * (ORDER + 1) + 5 * R) step(1'b1, 1'b1);

        // Mean +0.5, then mean 0.
        for (int i = 0; i < R * 8; i++) step(i % 4 == 3, 1'b1);
        for (int i = 0; i < R * 8; i++) step(i % 2 == 1, 1'b1);

        // Flow control: half-rate valid, then 37-clk gaps at and after a boundary.
        for (int i = 0; i < R * 2 * 6; i++) step(1'b0, i % 2 == 0);
        while (nacc % R != R - 1) step(1'b0, 1'b1);
        repeat (37) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (37) step(1'b0, 1'b0);
        for (int i = 0; i < R * 2 * 4; i++) step(1'b0, i % 2 == 0);

        // Random bits with random valid gaps.
        repeat (R * 30) step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);

        // Loopback from a modulator model, input 0 then 0x2000.
        u = 0;
        repeat (R * 20) begin
            lb = mod_bit(0);
            step(lb, 1'b1);
        end
        diff = held;
        checks++;
        assert (diff >= -64 && diff <= 64) else begin
            errors++;
            $error("FAIL loop_zero dout=%0d expected=0+-64", bus.dout);
        end
        repeat (R * 20) begin
            lb = mod_bit(32'h2000);
            step(lb, 1'b1);
        end
        diff = int'(bus.dout) - 8192;
        checks++;
        assert (diff >= -64 && diff <= 64) else begin
            errors++;
            $error("FAIL loop_step dout=%0d expected=8192+-64", bus.dout);
        end
        checks++;
        assert (bus.locked === 1'b1) else begin
            errors++;
            $error("FAIL loop_locked locked=%b expected=1", bus.locked);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
